// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ACCESS -> RESP, one access per three cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: p0 fixed priority).
module mem_arbiter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [31:0]       p1_wdata,
    input  logic [2:0]        p0_func3,
    input  logic [2:0]        p1_func3,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        func3_q, func3_d;
    logic              id_q, id_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              grant_s;
    logic              sel_s;
    logic              illegal_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;
`endif

    // Stores only allow b/h/w; halves and words must be naturally aligned.
    function automatic logic is_illegal(input logic we, input logic [ADDR_W-1:0] addr,
                                        input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = addr[0];
            3'b010:         bad = addr[1] | addr[0];
            default:        bad = 1'b1;
        endcase
        return bad | (we & f3[2]);
    endfunction

    assign illegal_s = is_illegal(we_q, addr_q, func3_q);

    // Arbitration: grants exist only in IDLE and never while reset is applied.
    always_comb begin
        sel_s   = ~p0_req;
        grant_s = (state_q == IDLE) && !rst && (p0_req || p1_req);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (p0_req && p1_req) begin
            sel_s = ~last_grant_q;
        end else begin
            sel_s = ~p0_req;
        end
`endif
        p0_gnt = grant_s && !sel_s;
        p1_gnt = grant_s && sel_s;
    end

    // Next-state and command/response capture.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        func3_d     = func3_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = ACCESS;
                    we_d    = sel_s ? p1_we    : p0_we;
                    addr_d  = sel_s ? p1_addr  : p0_addr;
                    wdata_d = sel_s ? p1_wdata : p0_wdata;
                    func3_d = sel_s ? p1_func3 : p0_func3;
                    id_d    = sel_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d     = RESP;
                rsp_id_d    = id_q;
                rsp_err_d   = illegal_s;
                rsp_rdata_d = (!we_q && !illegal_s) ? mem_rdata : 32'd0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember the most recent winner for the next simultaneous request.
    always_comb begin
        last_grant_d = grant_s ? sel_s : last_grant_q;
    end
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            func3_q     <= 3'd0;
            id_q        <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            func3_q     <= func3_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round-robin history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Memory command is live only in ACCESS; the write strobe is also killed by reset.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_func3 = 3'd0;
        if (state_q == ACCESS) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_func3 = func3_q;
            mem_read  = !we_q && !illegal_s;
            mem_write = we_q && !illegal_s && !rst;
        end else begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        rsp_valid = (state_q == RESP);
        rsp_id    = rsp_valid & rsp_id_q;
        rsp_err   = rsp_valid & rsp_err_q;
        rsp_rdata = rsp_valid ? rsp_rdata_q : 32'd0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a byte-array memory reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
    logic [5:0]  p0_addr = 6'd0, p1_addr = 6'd0;
    logic [31:0] p0_wdata = 32'd0, p1_wdata = 32'd0;
    logic [2:0]  p0_func3 = 3'd0, p1_func3 = 3'd0;
    logic        p0_gnt, p1_gnt, rsp_valid, rsp_id, rsp_err, mem_read, mem_write;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [5:0]  mem_addr;
    logic [2:0]  mem_func3;

    logic [7:0]  ext_mem [64];
    logic [7:0]  ref_mem [64];
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'd0;
    logic [31:0] ext_rd;
    logic        last_m = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_arbiter #(.ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_func3(p0_func3), .p1_func3(p1_func3), .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // External memory: combinational, extended read; write on the clock edge.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = ext_mem[mem_addr];
        b1 = ext_mem[mem_addr + 6'd1];
        b2 = ext_mem[mem_addr + 6'd2];
        b3 = ext_mem[mem_addr + 6'd3];
        case (mem_func3)
            3'b000:  ext_rd = {{24{b0[7]}}, b0};
            3'b001:  ext_rd = {{16{b1[7]}}, b1, b0};
            3'b100:  ext_rd = {24'd0, b0};
            3'b101:  ext_rd = {16'd0, b1, b0};
            default: ext_rd = {b3, b2, b1, b0};
        endcase
        mem_rdata = ovr_en ? ovr_data : ext_rd;
    end

    always @(posedge clk) begin
        if (mem_write) begin
            ext_mem[mem_addr] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'b00) ext_mem[mem_addr + 6'd1] <= mem_wdata[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                ext_mem[mem_addr + 6'd2] <= mem_wdata[23:16];
                ext_mem[mem_addr + 6'd3] <= mem_wdata[31:24];
            end
        end
    end

    function automatic int size_of(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_legal(input logic we, input logic [5:0] a, input logic [2:0] f);
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b0;
        if (we && f > 3'd2) return 1'b0;
        return (int'(a) % size_of(f)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [2:0] f);
        logic [31:0] v;
        int nb;
        nb = size_of(f);
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[(int'(a) + i) % 64]) << (8 * i));
        if (!f[2] && nb < 4 && v[8 * nb - 1]) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    task automatic ref_store(input logic [5:0] a, input logic [31:0] d, input logic [2:0] f);
        for (int i = 0; i < size_of(f); i++) ref_mem[(int'(a) + i) % 64] = 8'(d >> (8 * i));
    endtask

    // One full transaction: IDLE grant, ACCESS strobes, RESP pulse.
    task automatic run_txn(input logic r0, input logic r1,
                           input logic we0, input logic [5:0] a0, input logic [31:0] d0, input logic [2:0] f0,
                           input logic we1, input logic [5:0] a1, input logic [31:0] d1, input logic [2:0] f1,
                           output int win);
        logic we, ok;
        logic [5:0] a;
        logic [31:0] d, exp_rd;
        logic [2:0] f;
        @(negedge clk);
        p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0; p0_func3 = f0;
        p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1; p1_func3 = f1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = (r0 && r1) ? int'(!last_m) : (r0 ? 0 : 1);
`else
        win = r0 ? 0 : 1;
`endif
        last_m = win[0];
        #1;
        n_checks++;
        if ({p1_gnt, p0_gnt} !== (win == 1 ? 2'b10 : 2'b01) || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_gnt: got gnt=%b%b valid=%b, expected port %0d valid=0",
                     p1_gnt, p0_gnt, rsp_valid, win);
        end
        we = win ? we1 : we0; a = win ? a1 : a0; d = win ? d1 : d0; f = win ? f1 : f0;
        ok = ref_legal(we, a, f);
        exp_rd = (!ok || we) ? 32'd0 : (ovr_en ? ovr_data : ref_load(a, f));
        if (ok && we) ref_store(a, d, f);
        @(negedge clk);
        p0_req = 1'b0; p1_req = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== (ok && !we) || mem_write !== (ok && we) || mem_addr !== a ||
            mem_func3 !== f || mem_wdata !== d || rsp_valid !== 1'b0 || {p1_gnt, p0_gnt} !== 2'b00) begin
            n_errors++;
            $display("FAIL access_cmd: got rd=%b wr=%b addr=%0d f3=%0d wd=%h valid=%b, expected rd=%b wr=%b addr=%0d f3=%0d wd=%h valid=0",
                     mem_read, mem_write, mem_addr, mem_func3, mem_wdata, rsp_valid,
                     ok && !we, ok && we, a, f, d);
        end
        @(negedge clk);
        p0_req = 1'($urandom); p1_req = 1'($urandom);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== win[0] || rsp_err !== !ok || rsp_rdata !== exp_rd ||
            mem_read !== 1'b0 || mem_write !== 1'b0 || {p1_gnt, p0_gnt} !== 2'b00) begin
            n_errors++;
            $display("FAIL resp: got valid=%b id=%b err=%b rdata=%h gnt=%b%b, expected valid=1 id=%0d err=%b rdata=%h gnt=00",
                     rsp_valid, rsp_id, rsp_err, rsp_rdata, p1_gnt, p0_gnt, win, !ok, exp_rd);
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; p0_req = 1'b1; p1_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({p1_gnt, p0_gnt} !== 2'b00 || rsp_valid !== 1'b0 || mem_read !== 1'b0 ||
            mem_write !== 1'b0 || rsp_rdata !== 32'd0 || mem_addr !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_state: got gnt=%b%b valid=%b rd=%b wr=%b rdata=%h, expected all 0",
                     p1_gnt, p0_gnt, rsp_valid, mem_read, mem_write, rsp_rdata);
        end
        p0_req = 1'b0; p1_req = 1'b0; rst = 1'b0;
        last_m = 1'b0;
    endtask

    task automatic test_store_load;
        int w;
        run_txn(1'b1, 1'b0, 1'b1, 6'd8, 32'hDEADBEEF, 3'b010, 1'b0, 6'd0, 32'd0, 3'b010, w);
        run_txn(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 3'b010, 1'b0, 6'd8, 32'd0, 3'b010, w);
        n_checks++;
        if (ref_load(6'd8, 3'b010) !== 32'hDEADBEEF || ext_mem[8] !== 8'hEF || ext_mem[11] !== 8'hDE) begin
            n_errors++;
            $display("FAIL sw_commit: got mem[8]=%h mem[11]=%h, expected ef de", ext_mem[8], ext_mem[11]);
        end
    endtask

    task automatic test_misaligned;
        int w;
        run_txn(1'b1, 1'b0, 1'b0, 6'd3, 32'd0, 3'b001, 1'b0, 6'd0, 32'd0, 3'b000, w);
        run_txn(1'b1, 1'b0, 1'b1, 6'd4, 32'h12345678, 3'b100, 1'b0, 6'd0, 32'd0, 3'b000, w);
        run_txn(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 3'b000, 1'b0, 6'd2, 32'd0, 3'b010, w);
    endtask

    task automatic test_priority;
        int w;
        int exp_w;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        run_txn(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 3'b010, 1'b0, 6'd0, 32'd0, 3'b010, w);
`endif
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'b0, 6'd16, 32'd0, 3'b010, 1'b0, 6'd20, 32'd0, 3'b010, w);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_w = i % 2;
`else
            exp_w = 0;
`endif
            n_checks++;
            if (w !== exp_w || rsp_id !== 1'b0) begin
                n_errors++;
                $display("FAIL grant_order[%0d]: got %0d, expected %0d", i, w, exp_w);
            end
        end
    endtask

    task automatic test_sign_ext;
        int w;
        ovr_en = 1'b1; ovr_data = 32'hFFFFFF8A;
        run_txn(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 3'b000, 1'b0, 6'd4, 32'd0, 3'b000, w);
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL rdata_after_resp: got valid=%b rdata=%h, expected 0 0", rsp_valid, rsp_rdata);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_reset_in_access;
        int w;
        run_txn(1'b1, 1'b0, 1'b1, 6'd0, 32'h11223344, 3'b010, 1'b0, 6'd0, 32'd0, 3'b000, w);
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 6'd0; p0_wdata = 32'hCAFEF00D; p0_func3 = 3'b010;
        @(negedge clk);
        p0_req = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if (mem_write !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_write_gate: got mem_write=%b, expected 0", mem_write);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        last_m = 1'b0;
        run_txn(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 3'b000, 1'b0, 6'd0, 32'd0, 3'b010, w);
    endtask

    task automatic test_random;
        int w;
        logic r0, r1;
        logic [2:0] f0, f1;
        for (int i = 0; i < 60; i++) begin
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            f0 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            f1 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : (3'($urandom_range(0, 1)) << 2) | 3'($urandom_range(0, 2));
            run_txn(r0, r1,
                    1'($urandom), 6'($urandom) & 6'h3C | 6'($urandom_range(0, 3) == 0 ? $urandom : 0), $urandom, f0,
                    1'($urandom), 6'($urandom), $urandom, f1, w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            ext_mem[i] = 8'($urandom);
            ref_mem[i] = ext_mem[i];
        end
        test_reset();
        test_store_load();
        test_misaligned();
        test_priority();
        test_sign_ext();
        test_reset_in_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
